// File: rtl/sd_card_cmd.sv
// Card-side SD CMD-line engine: receives 48-bit host commands (CRC7/framing
// checked) and transmits 48-bit responses after a programmable N_CR gap.
module sd_card_cmd #(
    parameter int NCR = 2
) (
    input  logic        sd_clk,
    input  logic        rstn,
    input  logic        cmd_i,
    output logic        cmd_o,
    output logic        cmd_oe,
    output logic        rx_valid,
    output logic [5:0]  rx_idx,
    output logic [31:0] rx_arg,
    output logic        rx_crc_err,
    input  logic        resp_req,
    input  logic [5:0]  resp_idx,
    input  logic [31:0] resp_arg,
    output logic        resp_busy,
    output logic        resp_done,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_RX, S_NCR, S_TX} state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q;
    logic [45:0] sr_q;
    logic [6:0]  crc_q;
    logic        accept, rx_start, rx_last, ncr_last, tx_last;
    logic        tx_bit;

    function automatic logic [6:0] crc_next(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign dbg_state = state_q;

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        rx_start = 1'b0;
        rx_last  = 1'b0;
        ncr_last = 1'b0;
        tx_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A response request wins over a simultaneous start bit.
                if (resp_req) begin
                    accept  = 1'b1;
                    state_d = S_NCR;
                end else if (!cmd_i) begin
                    rx_start = 1'b1;
                    state_d  = S_RX;
                end
            end
            S_RX: if (cnt_q == 7'd47) begin
                rx_last = 1'b1;
                state_d = S_IDLE;
            end
            S_NCR: if (cnt_q == 7'd0) begin
                ncr_last = 1'b1;
                state_d  = S_TX;
            end
            S_TX: if (cnt_q == 7'd47) begin
                tx_last = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // cnt_q in TX holds the index of the bit currently on the pad.
    always_comb begin
        if (cnt_q < 7'd39)      tx_bit = sr_q[45];
        else if (cnt_q < 7'd46) tx_bit = crc_q[6];
        else                    tx_bit = 1'b1;
    end

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            sr_q       <= '0;
            crc_q      <= '0;
            cmd_o      <= 1'b1;
            cmd_oe     <= 1'b0;
            rx_valid   <= 1'b0;
            rx_idx     <= '0;
            rx_arg     <= '0;
            rx_crc_err <= 1'b0;
            resp_busy  <= 1'b0;
            resp_done  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            resp_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        sr_q      <= {1'b0, resp_idx, resp_arg, 7'b0};
                        cnt_q     <= 7'(NCR);
                        crc_q     <= '0;
                        resp_busy <= 1'b1;
                    end else if (rx_start) begin
                        cnt_q <= 7'd1;
                        crc_q <= '0;
                    end
                end
                S_RX: begin
                    sr_q  <= {sr_q[44:0], cmd_i};
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q <= 7'd39) crc_q <= crc_next(crc_q, cmd_i);
                    // sr_q now holds bits 1..46; cmd_i is the end bit.
                    if (rx_last) begin
                        rx_valid   <= 1'b1;
                        rx_idx     <= sr_q[44:39];
                        rx_arg     <= sr_q[38:7];
                        rx_crc_err <= (sr_q[6:0] != crc_q) | ~sr_q[45] | ~cmd_i;
                    end
                end
                S_NCR: begin
                    cnt_q <= cnt_q - 7'd1;
                    if (ncr_last) begin
                        cmd_oe <= 1'b1;
                        cmd_o  <= 1'b0;
                        cnt_q  <= '0;
                    end
                end
                S_TX: begin
                    if (tx_last) begin
                        cmd_oe    <= 1'b0;
                        cmd_o     <= 1'b1;
                        resp_busy <= 1'b0;
                        resp_done <= 1'b1;
                    end else begin
                        cmd_o <= tx_bit;
                        cnt_q <= cnt_q + 7'd1;
                        if (cnt_q < 7'd39) begin
                            sr_q  <= {sr_q[44:0], 1'b0};
                            crc_q <= crc_next(crc_q, sr_q[45]);
                        end else if (cnt_q < 7'd46) begin
                            crc_q <= {crc_q[5:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
